// File: rtl/seq_tx_arb.sv
// Two-requester round-robin arbiter that serializes the winner's pattern MSB-first
// to a shared detector and reports the match; SEQ_TX_ARB_CHECK_EN enables hit_o.
module seq_tx_arb #(
    parameter int PAT_W   = 12,
    parameter int GAP_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_i,
    input  logic [PAT_W-1:0] pat0_i,
    input  logic [PAT_W-1:0] pat1_i,
    output logic [1:0]       gnt_o,
    output logic             busy_o,
    output logic             x_o,
    output logic             vld_o,
    output logic [1:0]       done_o,
    input  logic             det_i,
    output logic             hit_o
);
    localparam int CW = $clog2(PAT_W);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, GAP} state_t;

    state_t           state, state_nx;
    logic             ptr;      // last owner; also the owner of the frame in flight
    logic [PAT_W-1:0] sreg;
    logic [CW-1:0]    bit_cnt;
    logic [3:0]       gap_cnt;
    logic             win;

    always_comb begin
        win = 1'b0;
        case (req_i)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~ptr;
            default: win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= 1'b1;
            sreg    <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (req_i != 2'b00) begin
                    ptr     <= win;
                    sreg    <= win ? pat1_i : pat0_i;
                    bit_cnt <= '0;
                end
                SHIFT: begin
                    sreg    <= {sreg[PAT_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                CHECK:   gap_cnt <= '0;
                GAP:     gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        gnt_o    = 2'b00;
        busy_o   = (state != IDLE);
        x_o      = 1'b0;
        vld_o    = 1'b0;
        done_o   = 2'b00;
        hit_o    = 1'b0;
        case (state)
            IDLE: if (req_i != 2'b00) state_nx = SHIFT;
            SHIFT: begin
                vld_o = 1'b1;
                x_o   = sreg[PAT_W-1];
                if (bit_cnt == '0) gnt_o = ptr ? 2'b10 : 2'b01;
                if (bit_cnt == CW'(PAT_W-1)) state_nx = CHECK;
            end
            CHECK: begin
                done_o = ptr ? 2'b10 : 2'b01;
`ifdef SEQ_TX_ARB_CHECK_EN
                hit_o  = det_i;
`endif
                state_nx = (GAP_CYC > 0) ? GAP : IDLE;
            end
            GAP: if (gap_cnt == 4'(GAP_CYC-1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

`ifndef SEQ_TX_ARB_CHECK_EN
    // detector feedback is deliberately ignored when the match check is compiled out
    logic unused_det;
    assign unused_det = det_i;
`endif

endmodule

// File: tb/tb_seq_tx_arb.sv
// Self-checking bench for seq_tx_arb: frame-level reference model, directed scenarios
// and randomized request/pattern traffic.
module tb_seq_tx_arb;
    localparam int PAT_W   = 12;
    localparam int GAP_CYC = 1;
`ifdef SEQ_TX_ARB_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_i = 2'b00;
    logic [PAT_W-1:0] pat0_i = '0, pat1_i = '0;
    logic [1:0]       gnt_o, done_o;
    logic             busy_o, x_o, vld_o, det_i, hit_o;

    seq_tx_arb #(.PAT_W(PAT_W), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .reset(reset), .req_i(req_i), .pat0_i(pat0_i), .pat1_i(pat1_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .x_o(x_o), .vld_o(vld_o), .done_o(done_o),
        .det_i(det_i), .hit_o(hit_o)
    );

    always #5 clk = ~clk;

    // external detector stand-in: last PAT_W serial bits compared to a programmed word
    logic [PAT_W-1:0] hist = '0;
    logic [PAT_W-1:0] det_prog = 12'hEDB;
    logic             det_sel = 1'b1, det_force = 1'b0;
    always @(posedge clk) if (vld_o) hist <= {hist[PAT_W-2:0], x_o};
    assign det_i = det_sel ? (hist == det_prog) : det_force;

    int vectors = 0, miscompares = 0;

    // reference model: a frame is PAT_W shift cycles, one check cycle, GAP_CYC gap
    // cycles, then idle; t counts cycles since the grant edge
    bit               m_act = 0, m_ptr = 1, m_own = 0;
    int               m_t = 0;
    logic [PAT_W-1:0] m_pat = '0;
    logic [7:0]       exp_v;

    function automatic logic [7:0] obs();
        return {gnt_o, busy_o, x_o, vld_o, done_o, hit_o};
    endfunction

    function automatic logic [7:0] model_out();
        logic [1:0] g, d;
        logic b, x, v, h;
        g = 0; d = 0; b = 0; x = 0; v = 0; h = 0;
        if (m_act) begin
            b = 1;
            if (m_t < PAT_W) begin
                v = 1;
                x = m_pat[PAT_W-1-m_t];
                if (m_t == 0) g = m_own ? 2'b10 : 2'b01;
            end else if (m_t == PAT_W) begin
                d = m_own ? 2'b10 : 2'b01;
                h = CHK ? det_i : 1'b0;
            end
        end
        return {g, b, x, v, d, h};
    endfunction

    task automatic step(input logic [1:0] r, input logic [PAT_W-1:0] a, input logic [PAT_W-1:0] b);
        req_i = r; pat0_i = a; pat1_i = b; det_force = 1'($urandom);
        @(posedge clk);
        if (!m_act) begin
            if (r != 2'b00) begin
                m_own = (r == 2'b01) ? 1'b0 : (r == 2'b10) ? 1'b1 : ~m_ptr;
                m_ptr = m_own;
                m_pat = m_own ? b : a;
                m_act = 1; m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == PAT_W + 1 + GAP_CYC) m_act = 0;
        end
        #1;
        exp_v = model_out();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m_act = 0; m_ptr = 1; m_t = 0;
        #1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_v = model_out();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        vectors++;
        if (obs() !== 8'h00) begin miscompares++; $display("FAIL reset_outs got %b want %b", obs(), 8'h00); end
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(2'b00, '0, '0);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL reset_idle cyc %0d got %b want %b", i, obs(), exp_v); end
        end
    endtask

    // one frame from requester 0; collects the serial bits and the check-cycle result
    task automatic test_pattern(input logic [PAT_W-1:0] pat, input bit exp_hit);
        logic [PAT_W-1:0] xs;
        logic [1:0] dn;
        logic hit;
        xs = '0; dn = 0; hit = 0;
        det_sel = 1'b1;
        apply_reset();
        for (int i = 0; i < PAT_W + 3 + GAP_CYC; i++) begin
            step(i == 0 ? 2'b01 : 2'b00, pat, ~pat);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL pattern %h cyc %0d got %b want %b", pat, i, obs(), exp_v); end
            if (vld_o) xs = {xs[PAT_W-2:0], x_o};
            if (done_o != 2'b00) begin dn = done_o; hit = hit_o; end
        end
        vectors++;
        if (xs !== pat) begin miscompares++; $display("FAIL pattern_bits got %h want %h", xs, pat); end
        vectors++;
        if ({dn, hit} !== {2'b01, exp_hit}) begin miscompares++; $display("FAIL pattern_done got %b/%b want 01/%b", dn, hit, exp_hit); end
    endtask

    task automatic test_alternate();
        int g_t[$];
        logic [1:0] g_v[$];
        apply_reset();
        for (int i = 0; i < 3 * (PAT_W + 2 + GAP_CYC) + 2; i++) begin
            step(2'b11, 12'h5A5, 12'hA5A);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL alternate cyc %0d got %b want %b", i, obs(), exp_v); end
            if (gnt_o != 2'b00) begin g_t.push_back(i); g_v.push_back(gnt_o); end
        end
        vectors++;
        if (g_v.size() < 3) begin miscompares++; $display("FAIL alternate_count got %0d want 3", g_v.size()); end
        else begin
            vectors++;
            if ({g_v[0], g_v[1], g_v[2]} !== 6'b01_10_01) begin
                miscompares++; $display("FAIL alternate_order got %b %b %b want 01 10 01", g_v[0], g_v[1], g_v[2]);
            end
            vectors++;
            if (g_t[1] - g_t[0] != 15 || g_t[2] - g_t[1] != 15) begin
                miscompares++; $display("FAIL alternate_spacing got %0d,%0d want 15,15", g_t[1] - g_t[0], g_t[2] - g_t[1]);
            end
        end
    endtask

    task automatic test_drop();
        logic [PAT_W-1:0] xs, orig;
        logic [1:0] dn;
        xs = '0; dn = 0; orig = 12'hC3B;
        apply_reset();
        for (int i = 0; i < PAT_W + 3 + GAP_CYC; i++) begin
            if (i <= 3) step(2'b10, 12'h000, orig);
            else        step(2'b00, 12'h000, 12'h3C4);
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL drop cyc %0d got %b want %b", i, obs(), exp_v); end
            if (vld_o) xs = {xs[PAT_W-2:0], x_o};
            if (done_o != 2'b00) dn = done_o;
        end
        vectors++;
        if (xs !== orig) begin miscompares++; $display("FAIL drop_bits got %h want %h", xs, orig); end
        vectors++;
        if (dn !== 2'b10) begin miscompares++; $display("FAIL drop_done got %b want 10", dn); end
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        seen_done = 0;
        apply_reset();
        for (int i = 0; i < 6; i++) step(i == 0 ? 2'b01 : 2'b00, 12'hFFF, 12'h000);
        reset = 1'b1;
        m_act = 0; m_ptr = 1;
        #1;
        vectors++;
        if (obs() !== 8'h00) begin miscompares++; $display("FAIL reset_mid_outs got %b want %b", obs(), 8'h00); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(2'b00, '0, '0);
            if (done_o != 2'b00) seen_done = 1;
        end
        vectors++;
        if (seen_done) begin miscompares++; $display("FAIL reset_mid_done got 1 want 0"); end
        step(2'b11, 12'h123, 12'h456);
        vectors++;
        if (gnt_o !== 2'b01) begin miscompares++; $display("FAIL reset_mid_gnt got %b want 01", gnt_o); end
    endtask

    task automatic test_random();
        logic [1:0] r;
        det_sel = 1'b0;
        apply_reset();
        r = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 2'($urandom);
            step(r, 12'($urandom), 12'($urandom));
            vectors++;
            if (obs() !== exp_v) begin miscompares++; $display("FAIL random cyc %0d req %b got %b want %b", i, r, obs(), exp_v); end
        end
        det_sel = 1'b1;
    endtask

    initial begin
        test_reset();
        det_prog = 12'hEDB;
        test_pattern(12'hEDB, CHK);
        test_pattern(12'hEDA, 1'b0);
        test_alternate();
        test_drop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
